// File: rtl/mfc_cpld_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mfc_cpld_bus_ctrl
// Bus-control logic for the XC9572 on the T35 multi-function card. Decodes
// Z80 I/O cycles addressed to the card (A15..A13 only), stretches them with
// READY until the Teensy 3.5 has serviced the cycle through a 4-phase
// req/ack handshake, and steers the 74245 data buffer.
//
// Ports
//   CLK      in   CPC bus clock, all state changes on the rising edge
//   RESET    in   synchronous, active-high reset
//   A15_13   in   Z80 address bits A15..A13
//   IOREQ_B  in   Z80 I/O request (active low)
//   M1_B     in   Z80 M1 (active low); M1 with IOREQ is interrupt ack
//   RD_B     in   Z80 read strobe (active low)
//   WR_B     in   Z80 write strobe (active low)
//   ack      in   Teensy acknowledge (gpio1), asynchronous to CLK
//   READY    out  Z80 wait control, 0 inserts wait states
//   req      out  request to Teensy (gpio0)
//   rnw      out  cycle type to Teensy (gpio2): 1 = read, 0 = write
//   bufoe_b  out  74245 output enable (active low)
//   bufdir   out  74245 direction: 1 = CPC to Teensy, 0 = Teensy to CPC
//   tmo_err  out  sticky wait-state timeout flag (gpio3)
// ---------------------------------------------------------------------------
module mfc_cpld_bus_ctrl #(
  parameter logic [2:0]  IO_SEL  = 3'b111,
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned TMO_MAX = 200
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] A15_13,
  input  logic       IOREQ_B,
  input  logic       M1_B,
  input  logic       RD_B,
  input  logic       WR_B,
  input  logic       ack,
  output logic       READY,
  output logic       req,
  output logic       rnw,
  output logic       bufoe_b,
  output logic       bufdir,
  output logic       tmo_err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_ACK0 = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_HOLD_RD   = 3'd3;
  localparam logic [2:0] S_RELEASE   = 3'd4;

  // Count value seen on the last cycle READY may still be held low.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

  logic [2:0]       r_state;
  logic             r_ack_m;
  logic             r_ack_s;
  logic [TMO_W-1:0] r_tmo;
  logic             r_ready;
  logic             r_req;
  logic             r_rnw;
  logic             r_bufoe_b;
  logic             r_bufdir;
  logic             r_tmo_err;

  logic w_sel;
  logic w_waiting;
  logic w_tmo_fire;

  assign w_sel      = !IOREQ_B && M1_B && (A15_13 == IO_SEL) && (!RD_B || !WR_B);
  assign w_waiting  = (r_state == S_WAIT_ACK0) || (r_state == S_REQ);
  assign w_tmo_fire = w_waiting && (r_tmo == TMO_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_ack_m   <= 1'b0;
      r_ack_s   <= 1'b0;
      r_tmo     <= '0;
      r_ready   <= 1'b1;
      r_req     <= 1'b0;
      r_rnw     <= 1'b0;
      r_bufoe_b <= 1'b1;
      r_bufdir  <= 1'b1;
      r_tmo_err <= 1'b0;
    end else begin
      r_ack_m <= ack;
      r_ack_s <= r_ack_m;

      if (w_tmo_fire) begin
        // Forced release; the Teensy's late ack is absorbed in RELEASE.
        r_ready   <= 1'b1;
        r_req     <= 1'b0;
        r_bufoe_b <= 1'b1;
        r_tmo_err <= 1'b1;
        r_state   <= S_RELEASE;
      end else begin
        if (w_waiting) begin
          r_tmo <= r_tmo + 1'b1;
        end
        case (r_state)
          S_IDLE: begin
            r_tmo <= '0;
            if (w_sel) begin
              r_ready  <= 1'b0;
              r_rnw    <= !RD_B;
              r_bufdir <= RD_B;
              r_state  <= S_WAIT_ACK0;
            end
          end
          S_WAIT_ACK0: begin
            if (!r_ack_s) begin
              r_req     <= 1'b1;
              // Writes open the buffer toward the Teensy for the whole request.
              r_bufoe_b <= r_rnw;
              r_state   <= S_REQ;
            end
          end
          S_REQ: begin
            if (r_ack_s) begin
              r_ready <= 1'b1;
              if (r_rnw) begin
                r_bufoe_b <= RD_B || IOREQ_B;
                r_state   <= S_HOLD_RD;
              end else begin
                r_bufoe_b <= 1'b1;
                r_state   <= S_RELEASE;
              end
            end
          end
          S_HOLD_RD: begin
            if (IOREQ_B) begin
              r_bufoe_b <= 1'b1;
              r_state   <= S_RELEASE;
            end else begin
              r_bufoe_b <= RD_B;
            end
          end
          S_RELEASE: begin
            if (IOREQ_B) begin
              r_req    <= 1'b0;
              r_bufdir <= 1'b1;
              r_state  <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign READY   = r_ready;
  assign req     = r_req;
  assign rnw     = r_rnw;
  assign bufoe_b = r_bufoe_b;
  assign bufdir  = r_bufdir;
  assign tmo_err = r_tmo_err;

endmodule

// File: tb/tb_mfc_cpld_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mfc_cpld_bus_ctrl
// Drives Z80 I/O cycles and a Teensy responder into mfc_cpld_bus_ctrl and
// compares every output on every cycle against a phase-level reference of
// the card's bus protocol, plus literal timing expectations for the
// directed scenarios.
// ---------------------------------------------------------------------------
module tb_mfc_cpld_bus_ctrl;

  localparam int TMO_MAX = 200;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [2:0] A15_13 = 3'b000;
  logic       IOREQ_B = 1'b1;
  logic       M1_B = 1'b1;
  logic       RD_B = 1'b1;
  logic       WR_B = 1'b1;
  logic       ack = 1'b0;
  logic       READY, req, rnw, bufoe_b, bufdir, tmo_err;

  mfc_cpld_bus_ctrl #(.IO_SEL(3'b111), .TMO_W(8), .TMO_MAX(TMO_MAX)) dut (
    .CLK(CLK), .RESET(RESET), .A15_13(A15_13), .IOREQ_B(IOREQ_B), .M1_B(M1_B),
    .RD_B(RD_B), .WR_B(WR_B), .ack(ack), .READY(READY), .req(req), .rnw(rnw),
    .bufoe_b(bufoe_b), .bufdir(bufdir), .tmo_err(tmo_err)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (protocol phases) ----------------
  localparam int PH_IDLE   = 0;  // no card cycle in progress
  localparam int PH_PREV   = 1;  // Z80 stalled, previous handshake draining
  localparam int PH_ASK    = 2;  // Z80 stalled, Teensy asked
  localparam int PH_DRIVE  = 3;  // read data served, Z80 finishing read
  localparam int PH_FINISH = 4;  // waiting for Z80 to end the I/O cycle

  int m_phase = PH_IDLE;
  int m_low_cycles = 0;
  bit m_is_read = 0, m_rnw = 0, m_tmo = 0, m_timed_out = 0, m_rd_low = 0;
  bit m_ack_pipe1 = 0, m_ack_pipe2 = 0;

  task automatic model_step();
    bit hit, ack_seen;
    hit = (IOREQ_B == 0) && (M1_B == 1) && (A15_13 == 3'b111) && (RD_B == 0 || WR_B == 0);
    if (RESET) begin
      m_phase = PH_IDLE; m_rnw = 0; m_tmo = 0; m_timed_out = 0;
      m_ack_pipe1 = 0; m_ack_pipe2 = 0;
      return;
    end
    ack_seen    = m_ack_pipe2;
    m_ack_pipe2 = m_ack_pipe1;
    m_ack_pipe1 = ack;
    if (m_phase == PH_PREV || m_phase == PH_ASK) begin
      m_low_cycles++;
      if (m_low_cycles == TMO_MAX) begin
        m_phase = PH_FINISH; m_timed_out = 1; m_tmo = 1;
      end else if (m_phase == PH_PREV && !ack_seen) begin
        m_phase = PH_ASK;
      end else if (m_phase == PH_ASK && ack_seen) begin
        m_phase = m_is_read ? PH_DRIVE : PH_FINISH;
      end
    end else if (m_phase == PH_IDLE) begin
      if (hit) begin
        m_phase = PH_PREV; m_is_read = (RD_B == 0); m_rnw = m_is_read; m_low_cycles = 0;
      end
    end else if (IOREQ_B) begin
      if (m_phase == PH_FINISH) m_timed_out = 0;
      m_phase = (m_phase == PH_DRIVE) ? PH_FINISH : PH_IDLE;
    end
    m_rd_low = (RD_B == 0) && (IOREQ_B == 0);
  endtask

  task automatic model_compare();
    bit e_ready, e_req, e_oe, e_dir;
    e_ready = !(m_phase == PH_PREV || m_phase == PH_ASK);
    e_req   = (m_phase == PH_ASK) || (m_phase == PH_DRIVE) || (m_phase == PH_FINISH && !m_timed_out);
    e_oe    = !((m_phase == PH_ASK && !m_is_read) || (m_phase == PH_DRIVE && m_rd_low));
    e_dir   = (m_phase == PH_IDLE) ? 1'b1 : !m_is_read;
    chk("m_READY", READY, e_ready);
    chk("m_req", req, e_req);
    chk("m_rnw", rnw, m_rnw);
    chk("m_bufoe_b", bufoe_b, e_oe);
    chk("m_bufdir", bufdir, e_dir);
    chk("m_tmo_err", tmo_err, m_tmo);
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      model_step();
      #1;
      model_compare();
    end
  end

  // ---------------- Teensy responder ----------------
  bit  resp_en = 1;
  int  ack_dly = -1;
  int  rel_dly = -1;
  longint t_ack_fall = 0;

  initial begin
    int d, g;
    forever begin
      @(negedge CLK);
      if (resp_en && req === 1'b1 && ack == 1'b0) begin
        d = (ack_dly >= 0) ? ack_dly : int'($urandom_range(0, 12));
        repeat (d) @(negedge CLK);
        ack = 1'b1;
        g = 0;
        while (req !== 1'b0 && g < 500) begin
          @(negedge CLK);
          g++;
        end
        chk("req_drop_bound", g < 500, 1);
        d = (rel_dly >= 0) ? rel_dly : int'($urandom_range(0, 8));
        repeat (d) @(negedge CLK);
        ack = 1'b0;
        t_ack_fall = $time;
      end
    end
  end

  // ---------------- Z80 bus tasks ----------------
  task automatic bus_start(input logic [2:0] a, input bit rd, input bit wr, input bit m1n);
    @(negedge CLK);
    A15_13 = a; M1_B = m1n; IOREQ_B = 1'b0; RD_B = !rd; WR_B = !wr;
  endtask

  task automatic bus_wait(input bit lit, input bit rd, output int lows);
    int g;
    g = 0;
    lows = 0;
    @(negedge CLK);
    if (lit) begin
      chk("ready_fall", READY, 0);
      chk("rnw_latch", rnw, rd);
      chk("bufdir_latch", bufdir, !rd);
    end
    while (READY !== 1'b1 && g < 400) begin
      lows++;
      g++;
      @(negedge CLK);
      if (lit && g == 1) begin
        chk("req_rise", req, 1);
        chk("bufoe_in_req", bufoe_b, rd);
      end
    end
    chk("ready_bound", g < 400, 1);
    if (lit) chk("bufoe_after_ack", bufoe_b, !rd);
  endtask

  task automatic bus_end(input int hold, input bit early_rd);
    repeat (hold) @(negedge CLK);
    if (early_rd) begin
      RD_B = 1'b1;
      @(negedge CLK);
    end
    IOREQ_B = 1'b1; RD_B = 1'b1; WR_B = 1'b1; M1_B = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lows, g, kind;
    logic [2:0] a;

    repeat (3) @(negedge CLK);
    chk("rst_READY", READY, 1);
    chk("rst_req", req, 0);
    chk("rst_rnw", rnw, 0);
    chk("rst_bufoe_b", bufoe_b, 1);
    chk("rst_bufdir", bufdir, 1);
    chk("rst_tmo_err", tmo_err, 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // write hit, ack 5 cycles after req
    ack_dly = 5; rel_dly = 2;
    bus_start(3'b111, 0, 1, 1);
    bus_wait(1, 0, lows);
    chk("write_low_cycles", lows, 9);
    bus_end(1, 0);
    @(negedge CLK);
    chk("write_req_drop", req, 0);
    repeat (6) @(negedge CLK);

    // read hit, ack 10 cycles after req
    ack_dly = 10;
    bus_start(3'b111, 1, 0, 1);
    bus_wait(1, 1, lows);
    chk("read_low_cycles", lows, 14);
    bus_end(1, 0);
    @(negedge CLK);
    chk("read_bufoe_off", bufoe_b, 1);
    @(negedge CLK);
    chk("read_req_drop", req, 0);
    repeat (6) @(negedge CLK);

    // address miss and interrupt acknowledge
    bus_start(3'b011, 0, 1, 1);
    bus_wait(0, 0, lows);
    chk("miss_low_cycles", lows, 0);
    bus_end(2, 0);
    bus_start(3'b111, 0, 0, 0);
    bus_wait(0, 0, lows);
    chk("intack_low_cycles", lows, 0);
    bus_end(2, 0);
    repeat (3) @(negedge CLK);

    // back-to-back writes with ack still high from the first
    ack_dly = 2; rel_dly = 8;
    bus_start(3'b111, 0, 1, 1);
    bus_wait(0, 0, lows);
    bus_end(0, 0);
    bus_start(3'b111, 0, 1, 1);
    @(negedge CLK);
    chk("b2b_ready_low", READY, 0);
    chk("b2b_req_held", req, 0);
    g = 0;
    while (req !== 1'b1 && g < 50) begin
      @(negedge CLK);
      g++;
    end
    chk("b2b_req_bound", g < 50, 1);
    chk("b2b_req_latency", int'(($time - t_ack_fall) / 10), 3);
    bus_wait(0, 0, lows);
    bus_end(1, 0);
    ack_dly = -1; rel_dly = -1;
    repeat (12) @(negedge CLK);

    // timeout on a read the Teensy never acknowledges
    resp_en = 0;
    bus_start(3'b111, 1, 0, 1);
    bus_wait(0, 1, lows);
    chk("tmo_low_cycles", lows, TMO_MAX);
    chk("tmo_flag", tmo_err, 1);
    chk("tmo_req", req, 0);
    chk("tmo_bufoe", bufoe_b, 1);
    ack = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      chk("late_ack_req", req, 0);
      chk("late_ack_ready", READY, 1);
    end
    ack = 1'b0;
    repeat (3) @(negedge CLK);
    bus_end(0, 0);
    repeat (4) @(negedge CLK);
    resp_en = 1;

    // randomized traffic
    for (int i = 0; i < 120; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 6)) : 3'b111;
      kind = int'($urandom_range(0, 2));
      bus_start(a, kind != 1, kind != 0, $urandom_range(0, 9) != 0);
      bus_wait(0, 0, lows);
      bus_end(int'($urandom_range(0, 2)), $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    chk("tmo_sticky", tmo_err, 1);
    repeat (12) @(negedge CLK);

    // reset in the middle of a read request
    resp_en = 0;
    bus_start(3'b111, 1, 0, 1);
    @(negedge CLK);
    @(negedge CLK);
    chk("mid_rst_pre_req", req, 1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("mid_rst_READY", READY, 1);
    chk("mid_rst_req", req, 0);
    chk("mid_rst_bufoe_b", bufoe_b, 1);
    chk("mid_rst_bufdir", bufdir, 1);
    chk("mid_rst_tmo_err", tmo_err, 0);
    RESET = 1'b0;
    IOREQ_B = 1'b1; RD_B = 1'b1;
    repeat (5) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
